// File: rtl/rf_wb_arbiter.sv
// Purpose : round-robin arbiter sharing the single register-file write port among NREQ writeback requesters.
// Latency : a transfer accepted in cycle t drives WR/RW/DW in cycle t+1; one write per cycle sustained.
// Backpr. : req_ready is a combinational one-hot grant; a requester holds addr/data while valid and not ready.
//
// Ports:
//   HCLK, HRESET          clock, asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot, zero when nothing is valid)
//   req_addr, req_data    packed per-requester destination register and data (slice i = [i*W +: W])
//   WR, RW, DW            registered register-file write enable / address / data
//   busy                  high while the post-reset clear sequencer runs
//
// Build option: define RF_INIT_CLEAR_EN to zero registers 1..63 after every reset
// before arbitration starts. Without it, arbitration runs from the first cycle and busy is 0.

module rf_wb_arbiter #(
   parameter int NREQ = 4,
   parameter int AW   = 6,
   parameter int DWID = 64
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DWID-1:0] req_data,
   output logic                 WR,
   output logic [AW-1:0]        RW,
   output logic [DWID-1:0]      DW,
   output logic                 busy
);

   localparam int PW = $clog2(NREQ);

   logic [PW-1:0]   r_rr_ptr;
   logic            r_wr;
   logic [AW-1:0]   r_rw;
   logic [DWID-1:0] r_dw;

   logic [NREQ-1:0] w_gnt;
   logic [PW-1:0]   w_gnt_idx;
   logic [PW-1:0]   w_ptr_nxt;
   logic            w_found;
   logic [AW-1:0]   w_sel_addr;
   logic [DWID-1:0] w_sel_data;
   logic            w_run;
   logic            w_xfer;

`ifdef RF_INIT_CLEAR_EN
   typedef enum logic [0:0] {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_cnt;
   logic          w_busy;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_state <= S_INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Leave INIT on the same edge that issues the write to the last register,
   // so the first RUN cycle overlaps that write on the RF port.
   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      case (r_state)
         S_INIT: begin
            w_busy = 1'b1;
            if (r_cnt == {AW{1'b1}}) begin
               w_state_nxt = S_RUN;
            end
         end
         default: begin
            w_state_nxt = S_RUN;
         end
      endcase
   end

   // Register 0 is never cleared, so the counter starts at 1 and saturates at the top.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_cnt <= AW'(1);
      end else if (r_state == S_INIT && r_cnt != {AW{1'b1}}) begin
         r_cnt <= r_cnt + AW'(1);
      end
   end

   assign w_run = (r_state == S_RUN) && !HRESET;
   assign busy  = w_busy;
`else
   assign w_run = !HRESET;
   assign busy  = 1'b0;
`endif

   // Search from r_rr_ptr upwards (mod NREQ); the first valid requester wins.
   always_comb begin
      w_gnt      = '0;
      w_gnt_idx  = '0;
      w_found    = 1'b0;
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         int v_idx;
         v_idx = (int'(r_rr_ptr) + k) % NREQ;
         if (!w_found && req_valid[v_idx]) begin
            w_found        = 1'b1;
            w_gnt[v_idx]   = 1'b1;
            w_gnt_idx      = PW'(v_idx);
            w_sel_addr     = req_addr[v_idx*AW +: AW];
            w_sel_data     = req_data[v_idx*DWID +: DWID];
         end
      end
   end

   assign w_ptr_nxt = PW'((int'(w_gnt_idx) + 1) % NREQ);
   assign w_xfer    = w_found && w_run;
   // Gating with w_run also blanks the grant while reset is asserted.
   assign req_ready = w_gnt & {NREQ{w_run}};

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_rr_ptr <= '0;
      end else if (w_xfer) begin
         r_rr_ptr <= w_ptr_nxt;
      end
   end

   // Write port register. Address 0 transfers update RW/DW but never raise WR.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_wr <= 1'b0;
         r_rw <= '0;
         r_dw <= '0;
      end else begin
         r_wr <= 1'b0;
`ifdef RF_INIT_CLEAR_EN
         if (r_state == S_INIT) begin
            r_wr <= 1'b1;
            r_rw <= r_cnt;
            r_dw <= '0;
         end
`endif
         if (w_xfer) begin
            r_wr <= (w_sel_addr != '0);
            r_rw <= w_sel_addr;
            r_dw <= w_sel_data;
         end
      end
   end

   assign WR = r_wr;
   assign RW = r_rw;
   assign DW = r_dw;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Purpose : directed self-checking bench for rf_wb_arbiter (NREQ=4, AW=6, DWID=64).
// Latency : expects registered write one cycle after each accepted transfer.
// Backpr. : drives valid patterns and checks the combinational one-hot grant each cycle.
// Inputs are driven 1 time unit after the rising edge and outputs sampled 1 unit later.

module tb_rf_wb_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 6;
   localparam int DWID = 64;

   logic                 HCLK;
   logic                 HRESET;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*DWID-1:0] req_data;
   logic                 WR;
   logic [AW-1:0]        RW;
   logic [DWID-1:0]      DW;
   logic                 busy;

   int checks   = 0;
   int failures = 0;

   localparam logic [63:0] D_SINGLE = 64'hDEADBEEF00000001;
   localparam logic [63:0] D_CONT   = 64'hA5A5000000000000;
   localparam logic [63:0] D_R3     = 64'h3333333333333333;

   rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DWID(DWID)) dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .WR        (WR),
      .RW        (RW),
      .DW        (DW),
      .busy      (busy)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DWID-1:0] d);
      req_addr[i*AW +: AW]     = a;
      req_data[i*DWID +: DWID] = d;
   endtask

   task automatic cyc();
      @(posedge HCLK);
      #1;
   endtask

   // Called right after reset release. With the clear sequencer present it checks the
   // 63 zero-writes with requester 0 waiting, then the first RUN grant, and leaves
   // req_valid low so no transfer is taken. Without it, busy must simply be low.
   task automatic init_phase();
`ifdef RF_INIT_CLEAR_EN
      req_valid = 4'b0001;
      for (int k = 1; k < 64; k++) begin
         #1;
         chk("init_busy", 64'(busy), 64'd1);
         chk("init_ready", 64'(req_ready), 64'd0);
         @(posedge HCLK);
         #1;
         chk("init_wr", 64'(WR), 64'd1);
         chk("init_rw", 64'(RW), 64'(k));
         chk("init_dw", 64'(DW), 64'd0);
      end
      chk("init_busy_done", 64'(busy), 64'd0);
      chk("init_first_grant", 64'(req_ready), 64'd1);
      req_valid = '0;
      #1;
`else
      #1;
      chk("busy_tied_low", 64'(busy), 64'd0);
`endif
   endtask

   initial begin
      HRESET    = 1'b1;
      req_valid = 4'b1111;
      req_addr  = '0;
      req_data  = '0;

      // Reset state, with every requester valid
      repeat (2) @(posedge HCLK);
      #1;
      chk("rst_wr", 64'(WR), 64'd0);
      chk("rst_rw", 64'(RW), 64'd0);
      chk("rst_dw", DW, 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      HRESET    = 1'b0;
      req_valid = '0;
      init_phase();

      // Contention: all valid for 8 cycles from rr_ptr=0 -> 0,1,2,3,0,1,2,3
      for (int i = 0; i < NREQ; i++) set_req(i, AW'(10 + i), D_CONT | 64'(i));
      for (int k = 0; k < 8; k++) begin
         cyc();
         req_valid = 4'b1111;
         #1;
         chk("cont_grant", 64'(req_ready), 64'(1 << (k % 4)));
         if (k > 0) begin
            chk("cont_wr", 64'(WR), 64'd1);
            chk("cont_rw", 64'(RW), 64'(10 + (k - 1) % 4));
            chk("cont_dw", DW, D_CONT | 64'((k - 1) % 4));
         end
      end
      cyc();
      req_valid = '0;
      #1;
      chk("cont_last_wr", 64'(WR), 64'd1);
      chk("cont_last_rw", 64'(RW), 64'd13);
      chk("cont_last_dw", DW, D_CONT | 64'd3);

      // Single write from requester 0 (rr_ptr back at 0)
      cyc();
      set_req(0, AW'(5), D_SINGLE);
      req_valid = 4'b0001;
      #1;
      chk("single_idle_wr", 64'(WR), 64'd0);
      chk("single_grant", 64'(req_ready), 64'b0001);
      cyc();
      req_valid = '0;
      #1;
      chk("single_wr", 64'(WR), 64'd1);
      chk("single_rw", 64'(RW), 64'd5);
      chk("single_dw", DW, D_SINGLE);
      chk("single_nogrant", 64'(req_ready), 64'd0);
      cyc();
      #1;
      chk("single_wr_drop", 64'(WR), 64'd0);
      chk("single_rw_hold", 64'(RW), 64'd5);
      chk("single_dw_hold", DW, D_SINGLE);

      // Pointer skip: rr_ptr=1, valid=1001 -> requester 3, then requester 0
      set_req(3, AW'(7), D_R3);
      cyc();
      req_valid = 4'b1001;
      #1;
      chk("skip_grant3", 64'(req_ready), 64'b1000);
      cyc();
      #1;
      chk("skip_grant0", 64'(req_ready), 64'b0001);
      chk("skip_wr3", 64'(WR), 64'd1);
      chk("skip_rw3", 64'(RW), 64'd7);
      chk("skip_dw3", DW, D_R3);
      cyc();
      req_valid = '0;
      #1;
      chk("skip_wr0", 64'(WR), 64'd1);
      chk("skip_rw0", 64'(RW), 64'd5);
      chk("skip_dw0", DW, D_SINGLE);

      // Address 0: accepted, pointer advances, no write enable
      cyc();
      set_req(1, AW'(0), 64'hFF);
      req_valid = 4'b0010;
      #1;
      chk("a0_grant", 64'(req_ready), 64'b0010);
      cyc();
      req_valid = 4'b0110;
      #1;
      chk("a0_wr", 64'(WR), 64'd0);
      chk("a0_rw", 64'(RW), 64'd0);
      chk("a0_dw", DW, 64'hFF);
      chk("a0_ptr_adv", 64'(req_ready), 64'b0100);

      // Reset mid-stream: pulse while requester 2's write is on the port
      cyc();
      req_valid = '0;
      #1;
      chk("pre_rst_wr", 64'(WR), 64'd1);
      chk("pre_rst_rw", 64'(RW), 64'd12);
      #1;
      HRESET    = 1'b1;
      req_valid = 4'b1111;
      #1;
      chk("mid_rst_wr", 64'(WR), 64'd0);
      chk("mid_rst_rw", 64'(RW), 64'd0);
      chk("mid_rst_dw", DW, 64'd0);
      chk("mid_rst_ready", 64'(req_ready), 64'd0);
      cyc();
      chk("mid_rst_hold_wr", 64'(WR), 64'd0);
      HRESET = 1'b0;
      init_phase();
      req_valid = 4'b1111;
      #1;
      chk("post_rst_ptr0", 64'(req_ready), 64'b0001);
      cyc();
      req_valid = '0;
      #1;
      chk("post_rst_wr", 64'(WR), 64'd1);
      chk("post_rst_rw", 64'(RW), 64'd5);
      chk("post_rst_dw", DW, D_SINGLE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
